data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the CPU's M-stage data port. It accepts load and store requests (word address, 4-bit byte-lane write enable, write data) and services them against an internal byte-writable word array with a programmable number of wait states. While an access is in flight it holds the pipeline with a stall output, and it returns load data on the cycle the stall drops. It sits between the CPU core's memory stage and on-chip data RAM, replacing a zero-latency combinational RAM model.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- WAIT_CYCLES, 2, extra access cycles before the array is touched; range 0..15.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- memread_i  in  1  load request for the current M-stage instruction.
- memwrite_i  in  4  byte-lane write enables, already lane-aligned; bit n writes byte n (bits 8n+7:8n).
- addr_i  in  32  byte address; word index = addr_i[log2(DEPTH_WORDS)+1:2]; addr_i[1:0] ignored.
- wdata_i  in  32  store data, lane-aligned.
- readdata_o  out  32  access result, valid in DONE.
- stall_o  out  1  hold the CPU pipeline (F/D/E/M enables low, W bubble).
- err_o  out  1  one-cycle pulse in DONE when the word index is out of range.

## Operation
- req = memread_i | (|memwrite_i).
- FSM states IDLE, ACCESS, DONE.
- IDLE: on req, latch addr, wdata, be and rd into *_q; cnt <= WAIT_CYCLES; go to ACCESS. stall_o = req (combinational).
- ACCESS: stall_o = 1. If cnt != 0, decrement cnt. If cnt == 0, perform the access and go to DONE:
  - Write the byte lanes with be_q set.
  - Load rdata_q with the post-write word; for a pure read this is the stored word.
- DONE: stall_o = 0; readdata_o = rdata_q; err_o = oor_q; always go to IDLE. Inputs are ignored in DONE, so the same instruction is never re-serviced.
- Read and write in the same request: the write is applied first and the read returns the merged word.
- Out of range (addr_i[31:log2(DEPTH_WORDS)+2] != 0): the write is suppressed, rdata_q = 32'h0 and oor_q = 1.
- Latched inputs: changes on the *_i ports after the IDLE capture have no effect on the access.

## Timing
- A request first visible in cycle T holds stall_o high in cycles T through T+WAIT_CYCLES+1. In cycle T+WAIT_CYCLES+2 (DONE), stall_o = 0 and readdata_o is valid. The CPU advances on the edge ending DONE.
- WAIT_CYCLES = 0 gives 3 cycles per access; the default gives 5.
- Back-to-back memory instructions each pay the full latency. There is no pipelining; a new request is first accepted the cycle after DONE.
- Array writes occur on the single edge leaving ACCESS with cnt == 0.
- readdata_o holds its value outside DONE (last rdata_q).
- Reset values: state = IDLE, cnt = 0, rdata_q = 0, oor_q = 0. Therefore readdata_o = 0 and err_o = 0. stall_o is forced to 0 while rst is low.
- The array contents are not reset.
- Reset mid-access (ACCESS or DONE): the block returns to IDLE immediately and no write occurs unless its edge already passed.

## Structure
- Shared package mem_if_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - the WAIT_CW counter width constant (4);
  - the default WAIT_CYCLES and DEPTH_WORDS values;
  - the lane constants BE_WORD = 4'b1111, BE_HALF0 = 4'b0011, BE_HALF1 = 4'b1100, and BE_B0 through BE_B3.
- One natural sub-module, sram_bytewe:
  - DEPTH_WORDS×32 array with 4 byte-write enables;
  - synchronous write, combinational read;
  - no reset.
- The FSM, counter, range check and output registers live in data_mem_responder.

## Test plan
- Reset then full-word write and read: write be=4'b1111, addr 0x10, data 0xDEADBEEF, then read addr 0x10. stall_o is high for 4 cycles per access; readdata_o = 0xDEADBEEF in DONE.
- Byte-lane merge: preload 0x11223344 at 0x20, then write be=4'b0100 with data 0x00AA0000. readdata_o in DONE = 0x11AA3344, and a subsequent read returns the same value.
- Out of range: read addr 0x0000_1000 with DEPTH_WORDS = 1024. readdata_o = 0 and err_o is high for exactly the DONE cycle. A write to the same address leaves word 0 unchanged.
- WAIT_CYCLES = 0 with back-to-back load, store, load to three addresses: each access shows stall 2 cycles then DONE, and no access is double-serviced.
- Reset mid-access: assert rst low during ACCESS with cnt = 1 on a write of 0xFFFFFFFF to 0x30. stall_o drops immediately, and a later read of 0x30 returns the prior contents.
- Input change after capture: change addr_i and wdata_i during ACCESS. The write still lands at the captured address with the captured data.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types and constants for the M-stage data memory responder.
// Holds the FSM state enum, counter width, default parameters and byte-lane masks.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int WAIT_CW             = 4;
    localparam int DEF_WAIT_CYCLES     = 2;
    localparam int DEF_DEPTH_WORDS     = 1024;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_B0    = 4'b0001;
    localparam logic [3:0] BE_B1    = 4'b0010;
    localparam logic [3:0] BE_B2    = 4'b0100;
    localparam logic [3:0] BE_B3    = 4'b1000;

    // Per-lane select of new data over old data; gives the post-write word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_bytewe.sv
// Word array with per-byte write enables: synchronous write, combinational read.
// Contents are deliberately not reset.
module sram_bytewe #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Byte-lane writes into the array.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: captures a load/store, waits WAIT_CYCLES,
// touches the array once, then presents the result for one unstalled cycle.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread_i,
    input  logic [3:0]  memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] readdata_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e               state_q, state_d;
    logic [WAIT_CW-1:0]   cnt_q, cnt_d;
    logic [29:0]          waddr_q, waddr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           be_q, be_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 oor_q, oor_d;

    logic                 req_s;
    logic                 oor_s;
    logic                 access_s;
    logic                 stall_s;
    logic [3:0]           sram_we_s;
    logic [31:0]          sram_rdata_s;
    logic [31:0]          merged_s;
    logic                 unused_addr_s;

    assign unused_addr_s = &{1'b0, addr_i[1:0]};

    assign req_s    = memread_i | (|memwrite_i);
    assign oor_s    = (waddr_q >> AW) != 30'd0;
    assign access_s = (state_q == ACCESS) && (cnt_q == {WAIT_CW{1'b0}});
    assign merged_s = merge_bytes(sram_rdata_s, wdata_q, be_q);

    sram_bytewe #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk_i   (clk),
        .we_i    (sram_we_s),
        .addr_i  (waddr_q[AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (sram_rdata_s)
    );

    // Next-state, capture and array-access decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        oor_d     = oor_q;
        stall_s   = 1'b0;
        sram_we_s = 4'b0000;
        case (state_q)
            IDLE: begin
                stall_s = req_s;
                if (req_s) begin
                    waddr_d = addr_i[31:2];
                    wdata_d = wdata_i;
                    be_d    = memwrite_i;
                    cnt_d   = WAIT_CW'(WAIT_CYCLES);
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                stall_s = 1'b1;
                if (access_s) begin
                    // Out-of-range words neither write nor return stale data.
                    sram_we_s = oor_s ? 4'b0000 : be_q;
                    rdata_d   = oor_s ? 32'h0000_0000 : merged_s;
                    oor_d     = oor_s;
                    state_d   = DONE;
                end else begin
                    cnt_d   = cnt_q - {{(WAIT_CW-1){1'b0}}, 1'b1};
                    state_d = ACCESS;
                end
            end
            DONE: begin
                stall_s = 1'b0;
                state_d = IDLE;
            end
            default: begin
                stall_s = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= {WAIT_CW{1'b0}};
            waddr_q <= 30'd0;
            wdata_q <= 32'h0000_0000;
            be_q    <= 4'b0000;
            rdata_q <= 32'h0000_0000;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            oor_q   <= oor_d;
        end
    end

    assign stall_o    = rst & stall_s;
    assign readdata_o = rdata_q;
    assign err_o      = oor_q & (state_q == DONE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: default-latency instance (u=0)
// and a zero-wait-state instance (u=1) sharing clock and reset.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memread [2];
    logic [3:0]  be      [2];
    logic [31:0] addr    [2];
    logic [31:0] wdata   [2];
    logic [31:0] rdata   [2];
    logic        stall   [2];
    logic        err     [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .memread_i(memread[0]), .memwrite_i(be[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .readdata_o(rdata[0]),
        .stall_o(stall[0]), .err_o(err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .memread_i(memread[1]), .memwrite_i(be[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .readdata_o(rdata[1]),
        .stall_o(stall[1]), .err_o(err[1])
    );

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkint(input string tag, input int got, input int exp);
        n_assert++;
        assert (got == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT in IDLE; returns likewise.
    task automatic access(input int u, input logic rd, input logic [3:0] bev,
                          input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] exp_data, input logic exp_err,
                          input string tag);
        int n;
        memread[u] = rd;
        be[u]      = bev;
        addr[u]    = a;
        wdata[u]   = w;
        #1;
        n = 0;
        while (stall[u] === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chkint({tag, " stall cycles"}, n, (u == 0) ? 4 : 2);
        chk32({tag, " data"}, rdata[u], exp_data);
        chk1({tag, " err"}, err[u], exp_err);
        @(posedge clk); #1;
        chk1({tag, " err after done"}, err[u], 1'b0);
        chk32({tag, " data held"}, rdata[u], exp_data);
        memread[u] = 1'b0;
        be[u]      = 4'b0000;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            memread[i] = 1'b1;
            be[i]      = 4'b0000;
            addr[i]    = 32'h0000_0000;
            wdata[i]   = 32'h0000_0000;
        end
        #2;
        chk1("reset stall0", stall[0], 1'b0);
        chk1("reset stall1", stall[1], 1'b0);
        chk32("reset rdata0", rdata[0], 32'h0000_0000);
        chk1("reset err0", err[0], 1'b0);
        memread[0] = 1'b0;
        memread[1] = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Full word write then read
        access(0, 1'b0, 4'b1111, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "wr10");
        access(0, 1'b1, 4'b0000, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, "rd10");

        // Byte-lane merge
        access(0, 1'b0, 4'b1111, 32'h20, 32'h1122_3344, 32'h1122_3344, 1'b0, "pre20");
        access(0, 1'b0, 4'b0100, 32'h20, 32'h00AA_0000, 32'h11AA_3344, 1'b0, "b2wr20");
        access(0, 1'b1, 4'b0000, 32'h20, 32'h0,         32'h11AA_3344, 1'b0, "rd20");
        access(0, 1'b1, 4'b0011, 32'h20, 32'h0000_5566, 32'h11AA_5566, 1'b0, "rdwr20");

        // Out of range
        access(0, 1'b0, 4'b1111, 32'h0,    32'h0102_0304, 32'h0102_0304, 1'b0, "pre0");
        access(0, 1'b1, 4'b0000, 32'h1000, 32'h0,         32'h0,         1'b1, "oor rd");
        access(0, 1'b0, 4'b1111, 32'h1000, 32'h5555_5555, 32'h0,         1'b1, "oor wr");
        access(0, 1'b1, 4'b0000, 32'h0,    32'h0,         32'h0102_0304, 1'b0, "rd0");

        // Zero wait states, back-to-back load/store/load
        access(1, 1'b0, 4'b1111, 32'h100, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, "z pre100");
        access(1, 1'b0, 4'b1111, 32'h108, 32'hA5A5_0002, 32'hA5A5_0002, 1'b0, "z pre108");
        access(1, 1'b1, 4'b0000, 32'h100, 32'h0,         32'hA5A5_0001, 1'b0, "z ld100");
        access(1, 1'b0, 4'b1111, 32'h104, 32'hC0DE_0003, 32'hC0DE_0003, 1'b0, "z st104");
        access(1, 1'b1, 4'b0000, 32'h108, 32'h0,         32'hA5A5_0002, 1'b0, "z ld108");
        access(1, 1'b1, 4'b0000, 32'h104, 32'h0,         32'hC0DE_0003, 1'b0, "z ld104");

        // Reset during ACCESS with cnt == 1
        access(0, 1'b0, 4'b1111, 32'h30, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, "pre30");
        be[0] = 4'b1111; addr[0] = 32'h30; wdata[0] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk1("midrst stall", stall[0], 1'b0);
        chk32("midrst rdata", rdata[0], 32'h0000_0000);
        be[0] = 4'b0000;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        access(0, 1'b1, 4'b0000, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0, "rd30");

        // Input change after capture
        access(0, 1'b0, 4'b1111, 32'h44, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, "pre44");
        be[0] = 4'b1111; addr[0] = 32'h40; wdata[0] = 32'h1234_5678;
        @(posedge clk); #1;
        addr[0] = 32'h44; wdata[0] = 32'h0000_0000;
        n = 0;
        while (stall[0] === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chkint("chg stall cycles", n, 3);
        chk32("chg data", rdata[0], 32'h1234_5678);
        @(posedge clk); #1;
        be[0] = 4'b0000;
        access(0, 1'b1, 4'b0000, 32'h40, 32'h0, 32'h1234_5678, 1'b0, "rd40");
        access(0, 1'b1, 4'b0000, 32'h44, 32'h0, 32'h0BAD_F00D, 1'b0, "rd44");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
